// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding responder for the 5-stage MIPS pipeline: shadows EX/ME/WB
// destinations and the HI/LO busy window, answers ID with forward selects and stop.
module hazard_fwd_unit #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] for_SrcA,
    input  logic [4:0] for_SrcB,
    input  logic       id_valid,
    input  logic       id_wen,
    input  logic [4:0] id_waddr,
    input  logic       id_is_load,
    input  logic       id_is_mult,
    input  logic       id_is_div,
    input  logic       id_rd_hilo,
    input  logic       id_to_ex_fire,
    input  logic       ex_to_me_fire,
    input  logic       me_to_wb_fire,
    input  logic       load_data_ok,
    input  logic       flush,
    output logic [2:0] forwardA,
    output logic [2:0] forwardB,
    output logic       stop,
    output logic       mdu_busy
);

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] waddr;
        logic       load;
    } slot_t;

    slot_t            r_ex, r_me, r_wb;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_selA, w_selB;
    logic             w_hilo_stall;

    // Result is {hazard, code}; the youngest matching producer decides alone.
    function automatic logic [3:0] fwd_sel(input logic [4:0] src, input slot_t ex,
                                           input slot_t me, input slot_t wb,
                                           input logic ld_ok);
        logic m_ex, m_me, m_wb;
        m_ex = ex.valid & ex.wen & (ex.waddr == src) & (src != 5'd0);
        m_me = me.valid & me.wen & (me.waddr == src) & (src != 5'd0);
        m_wb = wb.valid & wb.wen & (wb.waddr == src) & (src != 5'd0);
        if (m_ex)      fwd_sel = ex.load ? 4'b1_000 : 4'b0_001;
        else if (m_me) fwd_sel = !me.load ? 4'b0_010 : (ld_ok ? 4'b0_100 : 4'b1_000);
        else if (m_wb) fwd_sel = 4'b0_011;
        else           fwd_sel = 4'b0_000;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ex  <= '0;
            r_me  <= '0;
            r_wb  <= '0;
            r_cnt <= '0;
        end else begin
            if (flush)              r_ex <= '0;
            else if (id_to_ex_fire) r_ex <= '{1'b1, id_wen, id_waddr, id_is_load};
            else if (ex_to_me_fire) r_ex <= '0;

            if (flush)              r_me <= '0;
            else if (ex_to_me_fire) r_me <= r_ex;
            else if (me_to_wb_fire) r_me <= '0;

            r_wb <= me_to_wb_fire ? r_me : '0;

            // An issuing mult/div restarts the window; flush leaves it running.
            if (id_to_ex_fire && id_is_div)       r_cnt <= CNT_W'(DIV_LAT);
            else if (id_to_ex_fire && id_is_mult) r_cnt <= CNT_W'(MULT_LAT);
            else if (r_cnt != '0)                 r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_selA       = fwd_sel(for_SrcA, r_ex, r_me, r_wb, load_data_ok);
        w_selB       = fwd_sel(for_SrcB, r_ex, r_me, r_wb, load_data_ok);
        w_hilo_stall = mdu_busy & (id_rd_hilo | id_is_mult | id_is_div);
    end

    assign mdu_busy = (r_cnt != '0);
    assign forwardA = w_selA[2:0];
    assign forwardB = w_selB[2:0];
    assign stop     = id_valid & (w_selA[3] | w_selB[3] | w_hilo_stall);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Vector/scoreboard bench for hazard_fwd_unit: table of per-cycle stimulus with
// expected combinational outputs, plus div-window and async-reset sequences.
module tb_hazard_fwd_unit;

    localparam int IDV = 1,   WEN = 2,   LD  = 4,   MUL = 8,   DV = 16, RHL = 32;
    localparam int FIE = 64,  FEM = 128, FMW = 256, OK = 512, FL = 1024;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0, resetn;
    logic [4:0] for_SrcA, for_SrcB, id_waddr;
    logic       id_valid, id_wen, id_is_load, id_is_mult, id_is_div, id_rd_hilo;
    logic       id_to_ex_fire, ex_to_me_fire, me_to_wb_fire, load_data_ok, flush;
    logic [2:0] forwardA, forwardB;
    logic       stop, mdu_busy;

    hazard_fwd_unit #(.MULT_LAT(4), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .for_SrcA(for_SrcA), .for_SrcB(for_SrcB),
        .id_valid(id_valid), .id_wen(id_wen), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_mult(id_is_mult), .id_is_div(id_is_div),
        .id_rd_hilo(id_rd_hilo), .id_to_ex_fire(id_to_ex_fire),
        .ex_to_me_fire(ex_to_me_fire), .me_to_wb_fire(me_to_wb_fire),
        .load_data_ok(load_data_ok), .flush(flush), .forwardA(forwardA),
        .forwardB(forwardB), .stop(stop), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] sa, sb, wa;
        int         flags;
        logic [2:0] ea, eb;
        logic       es, ebz;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] ea, eb;
        logic       es, ebz;
    } exp_t;

    vec_t vt[$];
    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string n, int sa, int sb, int wa, int f,
                                int ea, int eb, int es, int ebz);
        vec_t v;
        v.name = n;  v.sa = 5'(sa); v.sb = 5'(sb); v.wa = 5'(wa); v.flags = f;
        v.ea = 3'(ea); v.eb = 3'(eb); v.es = (es != 0); v.ebz = (ebz != 0);
        return v;
    endfunction

    task automatic cmp(string n, logic [2:0] act, logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        exp_t e;
        for_SrcA      = v.sa;
        for_SrcB      = v.sb;
        id_waddr      = v.wa;
        id_valid      = (v.flags & IDV) != 0;
        id_wen        = (v.flags & WEN) != 0;
        id_is_load    = (v.flags & LD)  != 0;
        id_is_mult    = (v.flags & MUL) != 0;
        id_is_div     = (v.flags & DV)  != 0;
        id_rd_hilo    = (v.flags & RHL) != 0;
        id_to_ex_fire = (v.flags & FIE) != 0;
        ex_to_me_fire = (v.flags & FEM) != 0;
        me_to_wb_fire = (v.flags & FMW) != 0;
        load_data_ok  = (v.flags & OK)  != 0;
        flush         = (v.flags & FL)  != 0;
        e.name = v.name; e.ea = v.ea; e.eb = v.eb; e.es = v.es; e.ebz = v.ebz;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (sb_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard: queue empty at sample");
            return;
        end
        e = sb_q.pop_front();
        cmp({e.name, ".fwdA"}, forwardA, e.ea);
        cmp({e.name, ".fwdB"}, forwardB, e.eb);
        cmp({e.name, ".stop"}, 3'(stop), 3'(e.es));
        cmp({e.name, ".busy"}, 3'(mdu_busy), 3'(e.ebz));
    endtask

    // Inputs are driven just after a rising edge and outputs sampled mid-cycle.
    task automatic step(vec_t v);
        drive(v);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_m;
        resetn = 1'b0;
        drive(mk("init", 0, 0, 0, 0, 0, 0, 0, 0));
        void'(sb_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.fwdA", forwardA, 3'd0);
        cmp("reset.stop", 3'(stop), 3'd0);
        cmp("reset.busy", 3'(mdu_busy), 3'd0);
        resetn = 1'b1;

        vt.push_back(mk("rst_idle",      5, 0, 0, IDV,             0, 0, 0, 0));
        vt.push_back(mk("iss_addu3",     0, 0, 3, WEN|FIE,         0, 0, 0, 0));
        vt.push_back(mk("ex_fwd",        3, 3, 0, IDV|FEM,         1, 1, 0, 0));
        vt.push_back(mk("me_fwd",        3, 3, 0, IDV|FMW,         2, 2, 0, 0));
        vt.push_back(mk("wb_fwd",        3, 3, 0, IDV,             3, 3, 0, 0));
        vt.push_back(mk("wb_gone",       3, 3, 0, IDV,             0, 0, 0, 0));
        vt.push_back(mk("iss_lw7",       0, 0, 7, WEN|LD|FIE,      0, 0, 0, 0));
        vt.push_back(mk("ex_ld_stall",   0, 7, 0, IDV|FEM,         0, 0, 1, 0));
        vt.push_back(mk("me_ld_wait",    0, 7, 0, IDV,             0, 0, 1, 0));
        vt.push_back(mk("me_ld_ok",      0, 7, 0, IDV|OK|FMW,      0, 4, 0, 0));
        vt.push_back(mk("wb_ld",         0, 7, 0, IDV,             0, 3, 0, 0));
        vt.push_back(mk("iss_lw4",       0, 0, 4, WEN|LD|FIE,      0, 0, 0, 0));
        vt.push_back(mk("iss_addu4",     0, 0, 4, WEN|FIE|FEM,     0, 0, 0, 0));
        vt.push_back(mk("youngest",      4, 0, 0, IDV,             1, 0, 0, 0));
        vt.push_back(mk("iss_r0",        0, 0, 0, WEN|FIE|FEM|FMW, 0, 0, 0, 0));
        vt.push_back(mk("r0_masked",     0, 4, 0, IDV,             0, 2, 0, 0));
        vt.push_back(mk("iss_addu5",     0, 0, 5, WEN|FIE,         0, 0, 0, 0));
        vt.push_back(mk("iss_addu6",     0, 0, 6, WEN|FIE|FEM,     0, 0, 0, 0));
        vt.push_back(mk("pre_flush",     6, 5, 0, IDV|FL,          1, 2, 0, 0));
        vt.push_back(mk("post_flush",    6, 5, 0, IDV,             0, 0, 0, 0));
        vt.push_back(mk("iss_addu8",     0, 0, 8, WEN|FIE,         0, 0, 0, 0));
        vt.push_back(mk("iss_addu9",     0, 0, 9, WEN|FIE|FEM,     0, 0, 0, 0));
        vt.push_back(mk("flush_fmw",     9, 8, 0, IDV|FL|FMW,      1, 2, 0, 0));
        vt.push_back(mk("flush_wb_kept", 9, 8, 0, IDV,             0, 3, 0, 0));
        vt.push_back(mk("wb_drained",    9, 8, 0, IDV,             0, 0, 0, 0));
        vt.push_back(mk("iss_mult",      0, 0, 0, FIE|MUL,         0, 0, 0, 0));
        vt.push_back(mk("mult_b1_mflo",  0, 0, 0, IDV|RHL,         0, 0, 1, 1));
        vt.push_back(mk("mult_b2_mult",  0, 0, 0, IDV|MUL,         0, 0, 1, 1));
        vt.push_back(mk("mult_b3",       0, 0, 0, IDV,             0, 0, 0, 1));
        vt.push_back(mk("mult_b4",       0, 0, 0, 0,               0, 0, 0, 1));
        vt.push_back(mk("mult_done",     0, 0, 0, IDV|RHL,         0, 0, 0, 0));
        foreach (vt[i]) step(vt[i]);

        // Div window: mflo waits while a small reference counter is nonzero.
        step(mk("iss_div", 0, 0, 0, FIE|DV, 0, 0, 0, 0));
        cnt_m = DIV_LAT;
        for (int i = 1; i <= DIV_LAT + 1; i++) begin
            step(mk($sformatf("div_wait%0d", i), 0, 0, 0, IDV|RHL, 0, 0,
                    (cnt_m != 0), (cnt_m != 0)));
            if (cnt_m != 0) cnt_m--;
        end

        // Async reset in the middle of a div window.
        step(mk("iss_div2", 0, 0, 0, FIE|DV, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            step(mk("div2_busy", 0, 0, 0, IDV|RHL, 0, 0, 1, 1));
        drive(mk("mid_rst", 0, 0, 0, IDV|RHL, 0, 0, 0, 0));
        void'(sb_q.pop_front());
        #2;
        cmp("pre_rst.busy", 3'(mdu_busy), 3'd1);
        resetn = 1'b0;
        #1;
        cmp("mid_rst.busy", 3'(mdu_busy), 3'd0);
        cmp("mid_rst.stop", 3'(stop), 3'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(mk("after_rst", 0, 0, 0, IDV|RHL, 0, 0, 0, 0));

        if (sb_q.size() != 0) begin
            errors++; checks++;
            $display("FAIL scoreboard: %0d entries left over", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
